// File: rtl/axi_dmac_2d_frame_gen.sv
// Multi-frame 2D burst request generator: splits rows x frames into bursts that never cross
// a MAX_BYTES_PER_BURST boundary. Define AXI_DMAC_FRAME_GEN_CYCLIC_EN to honour desc_cyclic.
module axi_dmac_2d_frame_gen #(
  parameter int DMA_AXI_ADDR_WIDTH   = 32,
  parameter int DMA_LENGTH_WIDTH     = 24,
  parameter int BYTES_PER_BEAT_WIDTH = 3,
  parameter int MAX_BYTES_PER_BURST  = 128,
  parameter int MAX_NUM_FRAMES       = 8,
  localparam int AW = DMA_AXI_ADDR_WIDTH,
  localparam int LW = DMA_LENGTH_WIDTH,
  localparam int FW = ($clog2(MAX_NUM_FRAMES) < 1) ? 1 : $clog2(MAX_NUM_FRAMES),
  localparam int BW = $clog2(MAX_BYTES_PER_BURST)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          desc_valid,
  output logic          desc_ready,
  input  logic [AW-1:0] desc_addr,
  input  logic [LW-1:0] desc_x_length,
  input  logic [LW-1:0] desc_y_length,
  input  logic [AW-1:0] desc_stride,
  input  logic [AW-1:0] desc_frame_stride,
  input  logic [FW-1:0] desc_num_frames,
  input  logic          desc_cyclic,
  input  logic          abort,
  output logic          req_valid,
  input  logic          req_ready,
  output logic [AW-1:0] req_addr,
  output logic [BW-1:0] req_length,
  output logic          req_eol,
  output logic          req_eof,
  output logic [FW-1:0] req_frame,
  output logic          busy,
  output logic          eot
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [AW-1:0] ADDR_BEAT_MASK = AW'((64'd1 << BYTES_PER_BEAT_WIDTH) - 64'd1);
  localparam logic [BW-1:0] LEN_BEAT_MASK  = BW'((64'd1 << BYTES_PER_BEAT_WIDTH) - 64'd1);

  logic [1:0]    state;
  logic          abort_pend;

  logic [AW-1:0] start_addr, frame_addr, row_addr, addr;
  logic [AW-1:0] stride, frame_stride;
  logic [LW-1:0] x_len, y_len, row_rem, row_cnt;
  logic [FW-1:0] num_frames, frame;
  logic          cyclic;

  logic          desc_accept, req_accept;
  logic [BW-1:0] to_bound, cur_len;
  logic          last_in_row, last_row, last_burst;

  // Bytes-1 of the next burst: the row remainder, clipped at the burst boundary, beat rounded.
  function automatic logic [BW-1:0] burst_len(input logic [BW-1:0] room, input logic [LW-1:0] rem);
    if (rem <= LW'(room))
      burst_len = rem[BW-1:0] | LEN_BEAT_MASK;
    else
      burst_len = room | LEN_BEAT_MASK;
  endfunction

  always_comb begin
    to_bound    = ~addr[BW-1:0];
    cur_len     = burst_len(to_bound, row_rem);
    last_in_row = row_rem <= LW'(to_bound);
    last_row    = row_cnt == y_len;
    last_burst  = last_in_row && last_row && (frame == num_frames);
  end

  assign desc_ready  = state == ST_IDLE;
  assign req_valid   = state == ST_BURST;
  assign busy        = state == ST_BURST;
  assign eot         = state == ST_DONE;
  assign desc_accept = desc_ready && desc_valid;
  assign req_accept  = req_valid && req_ready;

  assign req_addr   = req_valid ? addr : '0;
  assign req_length = req_valid ? cur_len : '0;
  assign req_eol    = req_valid && last_in_row;
  assign req_eof    = req_valid && last_in_row && last_row;
  assign req_frame  = req_valid ? frame : '0;

  // Control: an abort seen while a request is stalled is remembered until that request is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      abort_pend <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          abort_pend <= 1'b0;
          if (desc_valid) state <= ST_BURST;
        end
        ST_BURST: begin
          if (req_ready) begin
            abort_pend <= 1'b0;
            if (abort || abort_pend || (last_burst && !cyclic)) state <= ST_DONE;
          end else if (abort) begin
            abort_pend <= 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Address walk: burst -> row -> frame -> (cyclic) restart at the descriptor start.
  always_ff @(posedge clk) begin
    if (desc_accept) begin
      start_addr   <= desc_addr & ~ADDR_BEAT_MASK;
      frame_addr   <= desc_addr & ~ADDR_BEAT_MASK;
      row_addr     <= desc_addr & ~ADDR_BEAT_MASK;
      addr         <= desc_addr & ~ADDR_BEAT_MASK;
      stride       <= desc_stride;
      frame_stride <= desc_frame_stride;
      x_len        <= desc_x_length;
      y_len        <= desc_y_length;
      num_frames   <= desc_num_frames;
      row_rem      <= desc_x_length;
      row_cnt      <= '0;
      frame        <= '0;
    end else if (req_accept) begin
      if (!last_in_row) begin
        addr    <= addr + AW'(cur_len) + AW'(1);
        row_rem <= row_rem - LW'(cur_len) - LW'(1);
      end else if (!last_row) begin
        row_cnt  <= row_cnt + LW'(1);
        row_addr <= row_addr + stride;
        addr     <= row_addr + stride;
        row_rem  <= x_len;
      end else if (frame != num_frames) begin
        frame      <= frame + FW'(1);
        frame_addr <= frame_addr + frame_stride;
        row_addr   <= frame_addr + frame_stride;
        addr       <= frame_addr + frame_stride;
        row_cnt    <= '0;
        row_rem    <= x_len;
      end else begin
        frame      <= '0;
        frame_addr <= start_addr;
        row_addr   <= start_addr;
        addr       <= start_addr;
        row_cnt    <= '0;
        row_rem    <= x_len;
      end
    end
  end

`ifdef AXI_DMAC_FRAME_GEN_CYCLIC_EN
  always_ff @(posedge clk) begin
    if (desc_accept) cyclic <= desc_cyclic;
  end
`else
  logic unused_desc_cyclic;
  assign unused_desc_cyclic = desc_cyclic;
  assign cyclic = 1'b0;
`endif

endmodule

// File: tb/tb_axi_dmac_2d_frame_gen.sv
// Bench for axi_dmac_2d_frame_gen: random descriptors and ready patterns checked against
// a nested-loop burst list model; covers aborts, backpressure, address wrap and reset.
module tb_axi_dmac_2d_frame_gen;

  localparam int AW = 32, LW = 24, FW = 3, BW = 7;
  localparam int MAXB = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          desc_valid, desc_ready;
  logic [AW-1:0] desc_addr, desc_stride, desc_frame_stride;
  logic [LW-1:0] desc_x_length, desc_y_length;
  logic [FW-1:0] desc_num_frames;
  logic          desc_cyclic, abort;
  logic          req_valid, req_ready;
  logic [AW-1:0] req_addr;
  logic [BW-1:0] req_length;
  logic          req_eol, req_eof;
  logic [FW-1:0] req_frame;
  logic          busy, eot;

  axi_dmac_2d_frame_gen dut (
    .clk(clk), .rst(rst),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_addr(desc_addr),
    .desc_x_length(desc_x_length), .desc_y_length(desc_y_length), .desc_stride(desc_stride),
    .desc_frame_stride(desc_frame_stride), .desc_num_frames(desc_num_frames),
    .desc_cyclic(desc_cyclic), .abort(abort),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_length(req_length),
    .req_eol(req_eol), .req_eof(req_eof), .req_frame(req_frame), .busy(busy), .eot(eot)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [BW-1:0] len;
    logic          eol;
    logic          eof;
    logic [FW-1:0] frame;
  } burst_t;

  burst_t exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Expected burst list for one pass over all frames, straight from the transfer rules.
  function automatic void build(input logic [AW-1:0] addr, input int x, input int y,
                                input logic [AW-1:0] st, input logic [AW-1:0] fst, input int nf);
    logic [AW-1:0] fa, ra, a;
    int rem, room, n;
    burst_t b;
    fa = addr & ~32'h7;
    for (int f = 0; f <= nf; f++) begin
      ra = fa;
      for (int r = 0; r <= y; r++) begin
        a   = ra;
        rem = x + 1;
        while (rem > 0) begin
          room    = MAXB - int'(a % 32'(MAXB));
          n       = (rem < room) ? rem : room;
          b.a     = a;
          b.len   = BW'(n - 1);
          b.eol   = (rem == n);
          b.eof   = (rem == n) && (r == y);
          b.frame = FW'(f);
          exp_q.push_back(b);
          a   = a + 32'(n);
          rem = rem - n;
        end
        ra = ra + st;
      end
      fa = fa + fst;
    end
  endfunction

  function automatic bit pick_ready(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return ($urandom % 3) != 0;
      default: return (cyc % 6) == 5;
    endcase
  endfunction

  // abort_at: -1 none, -2 random; index counts accepted bursts when abort is raised.
  task automatic run_xfer(input logic [AW-1:0] a, input int x, input int y,
                          input logic [AW-1:0] st, input logic [AW-1:0] fst, input int nf,
                          input bit cyc, input int rmode, input int abort_at_in,
                          input bit abort_with_desc);
    int acc, cnt, reps, abort_at;
    bit eff_cyc, rdy, abort_sent;
    burst_t obs;
    abort_at = abort_at_in;
`ifdef AXI_DMAC_FRAME_GEN_CYCLIC_EN
    eff_cyc = cyc;
`else
    eff_cyc = 1'b0;
`endif
    exp_q.delete();
    build(a, x, y, st, fst, nf);
    if (eff_cyc) begin
      reps = 1;
      while (reps < 3 || exp_q.size() <= abort_at) begin
        build(a, x, y, st, fst, nf);
        reps++;
      end
    end
    if (abort_at == -2) abort_at = $urandom_range(0, exp_q.size() - 1);
    if (eff_cyc && abort_at < 0) abort_at = exp_q.size() - 1;

    check("desc_ready_idle", 64'(desc_ready), 64'(1));
    desc_addr         = a;
    desc_x_length     = LW'(x);
    desc_y_length     = LW'(y);
    desc_stride       = st;
    desc_frame_stride = fst;
    desc_num_frames   = FW'(nf);
    desc_cyclic       = cyc;
    desc_valid        = 1'b1;
    abort             = abort_with_desc;
    @(negedge clk);
    desc_valid = 1'b0;
    abort      = 1'b0;
    check("busy_start", 64'(busy), 64'(1));
    acc = 0;
    cnt = 0;
    abort_sent = 1'b0;
    while (exp_q.size() > 0 && cnt < 4000) begin
      obs.a = req_addr; obs.len = req_length; obs.eol = req_eol; obs.eof = req_eof;
      obs.frame = req_frame;
      check("req_valid", 64'(req_valid), 64'(1));
      check("burst", 64'(obs), 64'(exp_q[0]));
      check("eot_early", 64'(eot), 64'(0));
      rdy = pick_ready(rmode, cnt);
      req_ready = rdy;
      if (abort_at >= 0 && acc == abort_at && !abort_sent) begin
        abort = 1'b1;
        abort_sent = 1'b1;
        while (exp_q.size() > 1) void'(exp_q.pop_back());
      end
      if (rdy) begin
        void'(exp_q.pop_front());
        acc++;
      end
      @(negedge clk);
      abort = 1'b0;
      cnt++;
    end
    if (cnt >= 4000) begin
      check("xfer_timeout", 64'(exp_q.size()), 64'(0));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      return;
    end
    req_ready = 1'b0;
    check("eot_pulse", 64'(eot), 64'(1));
    check("valid_done", 64'(req_valid), 64'(0));
    check("busy_done", 64'(busy), 64'(0));
    check("desc_ready_done", 64'(desc_ready), 64'(0));
    @(negedge clk);
    check("eot_one_cycle", 64'(eot), 64'(0));
    check("desc_ready_back", 64'(desc_ready), 64'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_desc_ready"}, 64'(desc_ready), 64'(1));
    check({tag, "_req_valid"}, 64'(req_valid), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_eot"}, 64'(eot), 64'(0));
    check({tag, "_req_fields"}, 64'({req_addr, req_length, req_eol, req_eof, req_frame}), 64'(0));
  endtask

  initial begin
    rst = 1'b1;
    desc_valid = 1'b0; desc_addr = '0; desc_x_length = '0; desc_y_length = '0;
    desc_stride = '0; desc_frame_stride = '0; desc_num_frames = '0; desc_cyclic = 1'b0;
    abort = 1'b0; req_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    run_xfer(32'h1000, 255, 0, 32'h0, 32'h0, 0, 1'b0, 0, -1, 1'b0);
    run_xfer(32'h1040, 255, 0, 32'h0, 32'h0, 0, 1'b0, 0, -1, 1'b0);
    run_xfer(32'h0, 127, 2, 32'h400, 32'h0, 0, 1'b0, 0, -1, 1'b0);
    run_xfer(32'h0, 127, 0, 32'h0, 32'h10000, 1, 1'b0, 0, -1, 1'b0);
    run_xfer(32'h1040, 255, 1, 32'h200, 32'h0, 0, 1'b0, 2, -1, 1'b0);
    run_xfer(32'hFFFF_FFC0, 255, 1, 32'h100, 32'h0, 0, 1'b0, 1, -1, 1'b0);
    run_xfer(32'h2000, 511, 3, 32'h300, 32'h4000, 2, 1'b0, 1, 5, 1'b0);
    run_xfer(32'h3000, 255, 0, 32'h0, 32'h0, 0, 1'b0, 0, -1, 1'b1);
    run_xfer(32'h0, 127, 0, 32'h0, 32'h0, 0, 1'b1, 1, 5, 1'b0);

    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_reset_outputs("idle_abort");

    for (int t = 0; t < 30; t++) begin
      run_xfer($urandom, int'($urandom_range(1, 64)) * 8 - 1, int'($urandom_range(0, 3)),
               $urandom & 32'hFFFF_FFF8, $urandom & 32'hFFFF_FFF8, int'($urandom_range(0, 2)),
               1'($urandom), int'($urandom_range(0, 2)),
               (($urandom % 4) == 0) ? -2 : -1, 1'($urandom));
    end

    desc_addr = 32'h5000; desc_x_length = LW'(1023); desc_y_length = LW'(3);
    desc_stride = 32'h1000; desc_num_frames = '0; desc_cyclic = 1'b0;
    desc_valid = 1'b1;
    @(negedge clk);
    desc_valid = 1'b0;
    req_ready = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    req_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_no_eot", 64'(eot), 64'(0));
    run_xfer(32'h1000, 255, 0, 32'h0, 32'h0, 0, 1'b0, 1, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
